fetch_unit: RTL
===============

# fetch_unit

Parametrised multi-word instruction fetch controller for the simple CPU. It fetches WORDS consecutive memory words starting at its internal program counter, using one read request per word and waiting for MFC on each. It assembles the words into a wide instruction register, advances the PC by WORDS, and reports done, or reports error on a memory timeout. It sits between the control sequencer (start/done) and the memory interface (MEM_EN/MEM_RW/MFC), replacing the single-word fetch FSM.

## Interface
- ADDR_W, 16, address and PC width
- DATA_W, 16, memory word width
- WORDS, 2, words per instruction; legal range 1..4
- TIMEOUT, 15, maximum WAIT cycles per word; 0 disables the timeout
- RESET_PC, 0, PC value after reset
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset; 0 = in reset
- start  in  1  request one instruction fetch; sampled only in IDLE
- pc_load  in  1  load the PC from pc_load_val; sampled only in IDLE
- pc_load_val  in  ADDR_W  new PC value
- MFC  in  1  memory function complete; sampled only in WAIT
- mem_rdata  in  DATA_W  read data; valid while MFC=1
- mem_addr  out  ADDR_W  registered read address
- MEM_EN  out  1  memory enable; one-cycle pulse per word
- MEM_RW  out  1  1 = read; equals MEM_EN
- IR  out  WORDS*DATA_W  fetched instruction; word 0 sits in bits [DATA_W-1:0]
- pc  out  ADDR_W  current program counter
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on a successful fetch
- error  out  1  one-cycle pulse on a timeout

## Operation
- States: IDLE, ADDR, REQ, WAIT, DONE, ERR.
- Internal registers:
  - word index idx, 0..WORDS-1
  - wait counter
  - shadow buffer of WORDS*DATA_W bits
- IDLE:
  - pc_load=1: pc <= pc_load_val. This has priority over start; a simultaneous start is dropped and is not remembered.
  - else start=1: idx <= 0, go to ADDR.
  - Both inputs are ignored in all other states.
- ADDR: mem_addr <= (pc + idx) mod 2^ADDR_W, wait counter <= 0, go to REQ.
- REQ: MEM_EN=MEM_RW=1 for this cycle only, go to WAIT.
- WAIT: MEM_EN=MEM_RW=0.
  - MFC=1: shadow slice idx <= mem_rdata. If idx=WORDS-1 go to DONE; else idx <= idx+1 and go to ADDR.
  - MFC=0: wait counter increments. If TIMEOUT>0 and this is the TIMEOUT-th WAIT cycle, go to ERR.
  - MFC=1 on the TIMEOUT-th cycle counts as success; success has priority over timeout.
- DONE:
  - done=1.
  - IR <= shadow buffer, committed at the exit edge.
  - pc <= (pc + WORDS) mod 2^ADDR_W.
  - Go to IDLE.
- ERR:
  - error=1.
  - IR and pc unchanged; partial words stay in the shadow buffer only.
  - Go to IDLE.
- MFC in IDLE, ADDR, REQ, DONE or ERR is ignored.

## Timing
- Reset values:
  - state IDLE, pc=RESET_PC, IR=0, mem_addr=0, idx=0
  - MEM_EN, MEM_RW, busy, done and error all 0
- Reset asserted mid-fetch: outputs return to reset values immediately and asynchronously; MEM_EN drops without waiting for a clock edge.
- Cycle numbering: start is sampled at edge E0.
  - Cycle 1 (first cycle after E0) is ADDR for word 0.
  - REQ occupies cycle 2.
  - The first WAIT cycle is cycle 3.
- Each word costs 2 + n cycles, where n is the number of WAIT cycles, n ≥ 1.
- With MFC high on the first WAIT cycle of every word, done is high in cycle 3*WORDS+1. For WORDS=2 that is cycle 7.
- IR and pc take their new values in the cycle after done; busy falls in that same cycle.
- The earliest next start is sampled at the edge ending the first IDLE cycle.
- Timeout: error is high in cycle (current word's REQ cycle) + TIMEOUT + 1.
- busy rises in cycle 1 and is high through the DONE or ERR cycle.

## Test plan
- Reset, then WORDS=2, pc=0x0010, MFC returned on the first WAIT cycle with data 0xAAAA then 0x5555 -> mem_addr 0x0010 then 0x0011; one MEM_EN pulse per word; done in cycle 7; IR=0x5555AAAA; pc=0x0012.
- Memory slowed to 4 WAIT cycles for each word -> done in cycle 13; no extra MEM_EN pulses while waiting.
- TIMEOUT=3, MFC never asserted -> error pulse in cycle 6; IR and pc keep their prior values; busy low in cycle 7.
- Timeout boundary, TIMEOUT=3: MFC on WAIT cycle 3 -> success, no error. MFC on WAIT cycle 4 is never reached because error is already raised.
- pc_load=1 with value 0xFFFF together with start=1 in IDLE -> pc=0xFFFF, no fetch. Then start -> addresses 0xFFFF then 0x0000; final pc=0x0001.
- start and pc_load pulsed during WAIT -> both ignored. Async reset asserted in a REQ cycle -> MEM_EN goes 0 immediately; pc=RESET_PC; IR=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Multi-word instruction fetch controller.
// Fetches WORDS consecutive memory words starting at the program counter,
// one read request per word, each waiting on MFC. The words are assembled in
// a shadow buffer and committed to IR only when the whole instruction has
// arrived; a memory timeout leaves IR and pc untouched and pulses error.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       WORDS    = 2,
    parameter int unsigned       TIMEOUT  = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pc_load,
    input  logic [ADDR_W-1:0]       pc_load_val,
    input  logic                    MFC,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    MEM_EN,
    output logic                    MEM_RW,
    output logic [WORDS*DATA_W-1:0] IR,
    output logic [ADDR_W-1:0]       pc,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    // The wait counter only has to reach TIMEOUT-1: the TIMEOUT-th WAIT cycle
    // is recognised by the comparison rather than by a further increment.
    localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORDS - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(WORDS);
    localparam bit                TO_EN     = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                    r_state;
    state_t                    w_next;

    logic [ADDR_W-1:0]         r_pc;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic [WORDS*DATA_W-1:0]   r_ir;
    logic [WORDS*DATA_W-1:0]   r_shadow;
    logic [IDX_W-1:0]          r_idx;
    logic [WCNT_W-1:0]         r_wcnt;

    logic                      w_last_word;
    logic                      w_timeout;
    logic                      w_mem_en;
    logic                      w_busy;
    logic                      w_done;
    logic                      w_error;

    assign w_last_word = (r_idx == IDX_LAST);
    assign w_timeout   = TO_EN && (r_wcnt == WCNT_LAST);

    // State register; reset forces IDLE so every state-decoded output drops at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded strobes; MFC wins over the timeout.
    always_comb begin
        w_next   = r_state;
        w_mem_en = 1'b0;
        w_busy   = 1'b1;
        w_done   = 1'b0;
        w_error  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (!pc_load && start) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                w_next = S_REQ;
            end
            S_REQ: begin
                w_mem_en = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (MFC) begin
                    w_next = w_last_word ? S_DONE : S_ADDR;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                w_error = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: pc, address, word index, wait counter, shadow buffer and IR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_mem_addr <= '0;
            r_ir       <= '0;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_wcnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pc_load) begin
                        r_pc <= pc_load_val;
                    end else if (start) begin
                        r_idx <= '0;
                    end
                end
                S_ADDR: begin
                    r_mem_addr <= r_pc + ADDR_W'(r_idx);
                    r_wcnt     <= '0;
                end
                S_WAIT: begin
                    if (MFC) begin
                        for (int unsigned w = 0; w < WORDS; w++) begin
                            if (r_idx == IDX_W'(w)) begin
                                r_shadow[w*DATA_W +: DATA_W] <= mem_rdata;
                            end
                        end
                        if (!w_last_word) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ir <= r_shadow;
                    r_pc <= r_pc + PC_STEP;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign MEM_EN   = w_mem_en;
    assign MEM_RW   = w_mem_en;
    assign IR       = r_ir;
    assign pc       = r_pc;
    assign busy     = w_busy;
    assign done     = w_done;
    assign error    = w_error;

endmodule
